// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for mips_cpu_harvard.
// After reset an internal sequencer zeroes every word (CLEAR), then accepts
// program words over a valid/ready loader port (LOAD), then serves fetches
// (RUN). Fetch data is combinational from instr_address.
// Optional build macro INSTR_MEM_CHECKSUM_EN adds an XOR checksum of all
// accepted load words on load_checksum; without it load_checksum reads 0.
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_enable,
  input  logic [31:0]                   instr_address,
  output logic [31:0]                   instr_readdata,
  output logic                          addr_error,
  input  logic                          load_valid,
  input  logic [31:0]                   load_data,
  output logic                          load_ready,
  input  logic                          load_done,
  output logic                          ready,
  output logic [$clog2(DEPTH_WORDS):0]  loaded_words,
  output logic [31:0]                   load_checksum
);

  localparam int          PTR_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] clr_ptr;
  logic [CNT_W-1:0] wr_ptr;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;

  logic [31:0]      offset;
  logic             hit;
  logic [PTR_W-1:0] rd_idx;

  // Loader handshake: only LOAD accepts words, and only on enabled cycles.
  assign load_ready   = clk_enable && (state == ST_LOAD);
  assign accept       = load_ready && load_valid;
  assign ready        = (state == ST_RUN);
  // wr_ptr never wraps and stops at DEPTH_WORDS, so it doubles as the count.
  assign loaded_words = wr_ptr;

  // Sequencer: CLEAR walks every word once, LOAD fills from index 0, RUN holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      wr_ptr  <= '0;
    end else if (clk_enable) begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == PTR_W'(DEPTH_WORDS - 1)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (accept) wr_ptr <= wr_ptr + 1'b1;
          // A word presented alongside load_done is still written first.
          if (load_done || (accept && (wr_ptr == CNT_W'(DEPTH_WORDS - 1))))
            state <= ST_RUN;
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear walk and the loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = 32'h0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (accept) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr[PTR_W-1:0];
        mem_wdata = load_data;
      end
    end
  end

  // Memory array write; contents are initialised by the CLEAR walk, not reset.
  always_ff @(posedge clk) begin
    if (clk_enable && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch decode: word-aligned hits inside the window; address 0 is the
  // CPU halt address and is a silent miss rather than an error.
  always_comb begin
    offset         = instr_address - BASE_ADDR;
    hit            = (offset < WIN_BYTES) && (offset[1:0] == 2'b00);
    rd_idx         = offset[PTR_W+1:2];
    instr_readdata = (hit && (state == ST_RUN)) ? mem[rd_idx] : 32'h0;
    addr_error     = !hit && (instr_address != 32'h0);
  end

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [31:0] checksum;

  // Running XOR of accepted load words, updated on the same edge as the write.
  always_ff @(posedge clk) begin
    if (reset) checksum <= 32'h0;
    else if (accept) checksum <= checksum ^ load_data;
  end

  assign load_checksum = checksum;
`else
  assign load_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed bench for mips_cpu_instr_memory (default parameters).
module tb_mips_cpu_instr_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        addr_error;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        ready;
  logic [8:0]  loaded_words;
  logic [31:0] load_checksum;

  int tests_run = 0;
  int tests_failed = 0;

  mips_cpu_instr_memory dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .addr_error     (addr_error),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .ready          (ready),
    .loaded_words   (loaded_words),
    .load_checksum  (load_checksum)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    load_done = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Wait for LOAD after a reset; timeout counts as a failure.
  task automatic wait_clear();
    int n = 0;
    while (load_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_clear: load_ready=%b after %0d cycles, need 1", load_ready, n);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic done);
    load_valid = 1'b1;
    load_data = d;
    load_done = done;
    step();
    load_valid = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic test_reset();
    int hi_cycle = -1;
    bit ready_seen = 0;
    clk_enable = 1'b1;
    instr_address = 32'hBFC00000;
    do_reset();
    tests_run++;
    if (load_ready !== 1'b0 || ready !== 1'b0 || loaded_words !== 9'd0 || instr_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: load_ready=%b ready=%b words=%0d rd=%h, need 0 0 0 0",
               load_ready, ready, loaded_words, instr_readdata);
    end
    tests_run++;
    if (addr_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_decode_hit: addr_error=%b need 0", addr_error);
    end
    instr_address = 32'h00000010;
    #1;
    tests_run++;
    if (addr_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_decode_miss: addr_error=%b need 1", addr_error);
    end
    instr_address = 32'hBFC00000;
    // Cycle k (0-based) after the reset edge; LOAD must begin at k=256.
    for (int k = 0; k < 300 && hi_cycle < 0; k++) begin
      if (ready !== 1'b0) ready_seen = 1;
      if (load_ready === 1'b1) hi_cycle = k;
      else step();
    end
    tests_run++;
    if (hi_cycle != 256) begin
      tests_failed++;
      $display("FAIL clear_length: load_ready rose at cycle %0d, need 256", hi_cycle);
    end
    tests_run++;
    if (ready_seen) begin
      tests_failed++;
      $display("FAIL clear_ready: ready went high during CLEAR, need 0");
    end
  endtask

  task automatic test_load_program();
    logic [31:0] prog [5];
    prog[0] = 32'h2484000C; prog[1] = 32'h24A5000A; prog[2] = 32'h00851025;
    prog[3] = 32'h00000008; prog[4] = 32'h24000000;
    for (int i = 0; i < 5; i++) load_word(prog[i], i == 4);
    tests_run++;
    if (ready !== 1'b1 || loaded_words !== 9'd5 || load_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL prog_done: ready=%b words=%0d load_ready=%b, need 1 5 0",
               ready, loaded_words, load_ready);
    end
    instr_address = 32'hBFC00000; #1;
    tests_run++;
    if (instr_readdata !== 32'h2484000C) begin
      tests_failed++;
      $display("FAIL read_w0: got %h need 2484000C", instr_readdata);
    end
    instr_address = 32'hBFC00008; #1;
    tests_run++;
    if (instr_readdata !== 32'h00851025 || addr_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_w2: got %h err=%b need 00851025 0", instr_readdata, addr_error);
    end
    instr_address = 32'hBFC00014; #1;
    tests_run++;
    if (instr_readdata !== 32'h0 || addr_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_w5: got %h err=%b need 0 0", instr_readdata, addr_error);
    end
    tests_run++;
`ifdef INSTR_MEM_CHECKSUM_EN
    if (load_checksum !== 32'h24A4102B) begin
      tests_failed++;
      $display("FAIL checksum_prog: got %h need 24A4102B", load_checksum);
    end
`else
    if (load_checksum !== 32'h0) begin
      tests_failed++;
      $display("FAIL checksum_off: got %h need 0", load_checksum);
    end
`endif
  endtask

  task automatic test_run_decode();
    logic [31:0] addr [4];
    logic        err  [4];
    addr[0] = 32'hBFC00002; err[0] = 1'b1;
    addr[1] = 32'h00000000; err[1] = 1'b0;
    addr[2] = 32'hBFC00400; err[2] = 1'b1;
    addr[3] = 32'hBFBFFFFC; err[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_address = addr[i]; #1;
      tests_run++;
      if (instr_readdata !== 32'h0 || addr_error !== err[i]) begin
        tests_failed++;
        $display("FAIL decode_%h: got %h err=%b need 0 err=%b", addr[i], instr_readdata, addr_error, err[i]);
      end
    end
    load_word(32'h12345678, 1'b0);
    instr_address = 32'hBFC00014; #1;
    tests_run++;
    if (loaded_words !== 9'd5 || instr_readdata !== 32'h0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_ignores_load: words=%0d w5=%h ready=%b need 5 0 1",
               loaded_words, instr_readdata, ready);
    end
  endtask

  task automatic test_full_load();
    do_reset();
    wait_clear();
    for (int i = 0; i < 255; i++) load_word(32'(i), 1'b0);
    tests_run++;
    if (ready !== 1'b0 || load_ready !== 1'b1 || loaded_words !== 9'd255) begin
      tests_failed++;
      $display("FAIL full_255: ready=%b load_ready=%b words=%0d need 0 1 255",
               ready, load_ready, loaded_words);
    end
    load_word(32'd255, 1'b0);
    tests_run++;
    if (ready !== 1'b1 || load_ready !== 1'b0 || loaded_words !== 9'd256) begin
      tests_failed++;
      $display("FAIL full_256: ready=%b load_ready=%b words=%0d need 1 0 256",
               ready, load_ready, loaded_words);
    end
    instr_address = 32'hBFC003FC; #1;
    tests_run++;
    if (instr_readdata !== 32'h000000FF || addr_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_last: got %h err=%b need 000000FF 0", instr_readdata, addr_error);
    end
    instr_address = 32'hBFC00200; #1;
    tests_run++;
    if (instr_readdata !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL full_mid: got %h need 00000080", instr_readdata);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    wait_clear();
    for (int i = 0; i < 3; i++) load_word(32'hC0DE0000 + 32'(i), 1'b0);
    do_reset();
    tests_run++;
    if (loaded_words !== 9'd0 || load_ready !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midload_reset: words=%0d load_ready=%b ready=%b need 0 0 0",
               loaded_words, load_ready, ready);
    end
    wait_clear();
    load_word(32'hAAAAAAAA, 1'b1);
    instr_address = 32'hBFC00000; #1;
    tests_run++;
    if (instr_readdata !== 32'hAAAAAAAA || loaded_words !== 9'd1 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_w0: got %h words=%0d ready=%b need AAAAAAAA 1 1",
               instr_readdata, loaded_words, ready);
    end
    instr_address = 32'hBFC00004; #1;
    tests_run++;
    if (instr_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reload_w1_cleared: got %h need 0", instr_readdata);
    end
`ifdef INSTR_MEM_CHECKSUM_EN
    tests_run++;
    if (load_checksum !== 32'hAAAAAAAA) begin
      tests_failed++;
      $display("FAIL checksum_reload: got %h need AAAAAAAA", load_checksum);
    end
`endif
  endtask

  task automatic test_enable_stall();
    bit stall_bad = 0;
    do_reset();
    wait_clear();
    load_word(32'h11111111, 1'b0);
    clk_enable = 1'b0;
    load_valid = 1'b1;
    load_data = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (load_ready !== 1'b0 || loaded_words !== 9'd1) stall_bad = 1;
      step();
    end
    tests_run++;
    if (stall_bad || loaded_words !== 9'd1) begin
      tests_failed++;
      $display("FAIL stall_hold: load_ready=%b words=%0d need 0 1", load_ready, loaded_words);
    end
    clk_enable = 1'b1;
    #1;
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_reenable_ready: load_ready=%b need 1", load_ready);
    end
    step();
    load_valid = 1'b0;
    tests_run++;
    if (loaded_words !== 9'd2) begin
      tests_failed++;
      $display("FAIL stall_accept: words=%0d need 2", loaded_words);
    end
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    instr_address = 32'hBFC00004; #1;
    tests_run++;
    if (instr_readdata !== 32'h55555555 || ready !== 1'b1 || loaded_words !== 9'd2) begin
      tests_failed++;
      $display("FAIL stall_data: got %h ready=%b words=%0d need 55555555 1 2",
               instr_readdata, ready, loaded_words);
    end
  endtask

  initial begin
    reset = 1'b0;
    clk_enable = 1'b1;
    instr_address = 32'h0;
    load_valid = 1'b0;
    load_data = 32'h0;
    load_done = 1'b0;
    #1;
    test_reset();
    test_load_program();
    test_run_decode();
    test_full_load();
    test_reset_mid_load();
    test_enable_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
